// File: rtl/mem_initiator_if.sv
// Control-unit request/response bundle for mem_initiator.
// The control unit owns the master side; the initiator owns the slave side.
interface mem_initiator_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              req;
  logic [1:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic              zero;

  modport master (
    output req, op, addr, wdata,
    input  busy, done, err, rdata, zero
  );

  modport slave (
    input  req, op, addr, wdata,
    output busy, done, err, rdata, zero
  );
endinterface

// File: rtl/mem_initiator.sv
// Sequences control-unit READ / WRITE / INC requests onto a single-port memory.
// Every output is a register; writes get one cycle of address/data setup and hold.
module mem_initiator #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_initiator_if.slave    cpu,
  output logic [ADDR_W-1:0] mem_adress,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_indata,
  input  logic [DATA_W-1:0] mem_outdata
);

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpInc   = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWsetup,
    StWstrobe,
    StWhold,
    StDone
  } state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              zero_q;
  logic [ADDR_W-1:0] adr_q;
  logic              rd_q;
  logic              wr_q;
  logic [DATA_W-1:0] ind_q;
  logic [DATA_W-1:0] inc_sum;

  assign inc_sum = mem_outdata + DATA_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      zero_q  <= 1'b0;
      adr_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ind_q   <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (cpu.req) begin
            op_q  <= cpu.op;
            adr_q <= cpu.addr;
            unique case (cpu.op)
              OpRead, OpInc: begin
                state_q <= StRd;
                rd_q    <= 1'b1;
                busy_q  <= 1'b1;
              end
              OpWrite: begin
                state_q <= StWsetup;
                ind_q   <= cpu.wdata;
                busy_q  <= 1'b1;
              end
              default: begin
                // Reserved op completes immediately with no memory access.
                state_q <= StDone;
                done_q  <= 1'b1;
                err_q   <= 1'b1;
              end
            endcase
          end else begin
            state_q <= StIdle;
          end
        end
        StRd: begin
          rd_q <= 1'b0;
          if (op_q == OpInc) begin
            rdata_q <= inc_sum;
            ind_q   <= inc_sum;
            zero_q  <= (inc_sum == '0);
            state_q <= StWsetup;
          end else begin
            rdata_q <= mem_outdata;
            zero_q  <= (mem_outdata == '0);
            state_q <= StDone;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        StWsetup: begin
          wr_q    <= 1'b1;
          state_q <= StWstrobe;
        end
        StWstrobe: begin
          wr_q    <= 1'b0;
          state_q <= StWhold;
        end
        StWhold: begin
          state_q <= StDone;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.busy   = busy_q;
  assign cpu.done   = done_q;
  assign cpu.err    = err_q;
  assign cpu.rdata  = rdata_q;
  assign cpu.zero   = zero_q;
  assign mem_adress = adr_q;
  assign mem_read   = rd_q;
  assign mem_write  = wr_q;
  assign mem_indata = ind_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator: vector table plus hand-written corner sequences,
// with a 4096x16 behavioural memory on the memory port.
module tb_mem_initiator;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 16;
  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [11:0] addr;
    logic [15:0] wdata;
    int          cycles;
    logic [15:0] rdata;
    logic        zero;
    logic        err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] mem_adress;
  logic mem_read, mem_write;
  logic [DW-1:0] mem_indata, mem_outdata;
  logic [DW-1:0] mem [4096];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_initiator_if #(.ADDR_W(AW), .DATA_W(DW)) cpu ();

  mem_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu         (cpu),
    .mem_adress  (mem_adress),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_indata  (mem_indata),
    .mem_outdata (mem_outdata)
  );

  always @(posedge clk) if (mem_write) mem[mem_adress] <= mem_indata;
  assign mem_outdata = mem[mem_adress];

  always @(negedge clk) begin
    if (mem_read && mem_write) begin
      n_bad++;
      $display("FAIL rd_wr_overlap: mem_read=%b mem_write=%b required not both 1",
               mem_read, mem_write);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {14'd0, cpu.busy, cpu.done, cpu.err, cpu.rdata, cpu.zero,
            mem_adress, mem_read, mem_write, mem_indata};
  endfunction

  // Called at a negedge; returns at the negedge after the DONE cycle.
  task automatic run_txn(input vec_t v);
    int n, wr_cnt, rd_cnt, wr_at;
    bit seen;
    logic [15:0] exp_ind;
    exp_ind = (v.op == OP_INC) ? v.rdata : v.wdata;
    cpu.req = 1'b1; cpu.op = v.op; cpu.addr = v.addr; cpu.wdata = v.wdata;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0; cpu.addr = ~v.addr; cpu.wdata = ~v.wdata;
    n = 1; seen = 0; wr_cnt = 0; rd_cnt = 0; wr_at = 0;
    while (!seen && n <= 20) begin
      if (mem_write) begin wr_cnt++; wr_at = n; end
      if (mem_read) rd_cnt++;
      if (cpu.busy) chk("txn_addr", mem_adress, v.addr);
      if (cpu.busy && (v.op == OP_WR || (v.op == OP_INC && n >= 2)))
        chk("txn_wdata", mem_indata, exp_ind);
      if (cpu.done) seen = 1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL txn_timeout: op=%0d addr=%0h no done within 20 cycles", v.op, v.addr);
    end else begin
      chk("txn_cycles", n, v.cycles);
      chk("txn_rdata", cpu.rdata, v.rdata);
      chk("txn_zero", cpu.zero, v.zero);
      chk("txn_err", cpu.err, v.err);
      chk("txn_busy_done", cpu.busy, 0);
      chk("txn_wr_cnt", wr_cnt, (v.op == OP_WR || v.op == OP_INC) ? 1 : 0);
      chk("txn_wr_at", wr_at, (v.op == OP_WR) ? 2 : (v.op == OP_INC) ? 3 : 0);
      chk("txn_rd_cnt", rd_cnt, (v.op == OP_RD || v.op == OP_INC) ? 1 : 0);
    end
    @(negedge clk);
    chk("txn_done_pulse", cpu.done, 0);
    chk("txn_idle_busy", cpu.busy, 0);
  endtask

  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 1;
    while (!cpu.done && n < 12) begin
      @(negedge clk);
      n++;
    end
    chk(name, n, exp_n);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{OP_WR,  12'h0A5, 16'h1234, 4, 16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{OP_RD,  12'h0A5, 16'h0000, 2, 16'h1234, 1'b0, 1'b0};
    vecs[2]  = '{OP_WR,  12'hFFF, 16'hFFFF, 4, 16'h1234, 1'b0, 1'b0};
    vecs[3]  = '{OP_INC, 12'hFFF, 16'h0000, 5, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{OP_RD,  12'hFFF, 16'h0000, 2, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{OP_WR,  12'h010, 16'h7FFF, 4, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{OP_INC, 12'h010, 16'h0000, 5, 16'h8000, 1'b0, 1'b0};
    vecs[7]  = '{OP_RD,  12'h010, 16'h0000, 2, 16'h8000, 1'b0, 1'b0};
    vecs[8]  = '{OP_RSV, 12'h123, 16'h4321, 1, 16'h8000, 1'b0, 1'b1};
    vecs[9]  = '{OP_RD,  12'h0A5, 16'h0000, 2, 16'h1234, 1'b0, 1'b0};
    vecs[10] = '{OP_WR,  12'h001, 16'h00C3, 4, 16'h1234, 1'b0, 1'b0};

    // Reset and idle.
    rst_n = 1'b0;
    cpu.req = 1'b0; cpu.op = 2'b00; cpu.addr = '0; cpu.wdata = '0;
    #1;
    chk("reset_outs", all_outs(), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy_rd_wr", {cpu.busy, mem_read, mem_write}, 0);
    end

    for (int i = 0; i < 11; i++) run_txn(vecs[i]);

    // Back-to-back: req held through the READ's DONE cycle.
    cpu.req = 1'b1; cpu.op = OP_RD; cpu.addr = 12'h001; cpu.wdata = '0;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_rd_busy", {cpu.busy, cpu.done, mem_read}, 3'b101);
    @(negedge clk);
    chk("b2b_rd_done", {cpu.busy, cpu.done}, 2'b01);
    chk("b2b_rd_rdata", cpu.rdata, 16'h00C3);
    cpu.op = OP_WR; cpu.addr = 12'h002; cpu.wdata = 16'h5A5A;
    @(negedge clk);
    chk("b2b_wr_busy", {cpu.busy, cpu.done, mem_read}, 3'b100);
    chk("b2b_wr_addr", mem_adress, 12'h002);
    chk("b2b_wr_data", mem_indata, 16'h5A5A);
    cpu.req = 1'b0;
    wait_done("b2b_wr_cycles", 4);
    @(negedge clk);
    run_txn('{OP_RD, 12'h002, 16'h0000, 2, 16'h5A5A, 1'b0, 1'b0});

    // req asserted mid-WRITE must be ignored.
    cpu.req = 1'b1; cpu.op = OP_WR; cpu.addr = 12'h003; cpu.wdata = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    cpu.addr = 12'h004; cpu.wdata = 16'h2222;
    @(negedge clk);
    cpu.req = 1'b0;
    chk("ign_strobe", mem_write, 1);
    chk("ign_addr", mem_adress, 12'h003);
    chk("ign_data", mem_indata, 16'h1111);
    wait_done("ign_cycles", 3);
    @(negedge clk);
    chk("ign_no_extra", {cpu.busy, cpu.done, mem_read, mem_write}, 0);
    @(negedge clk);
    chk("ign_no_extra2", {cpu.busy, cpu.done, mem_read, mem_write}, 0);
    run_txn('{OP_RD, 12'h003, 16'h0000, 2, 16'h1111, 1'b0, 1'b0});

    // Reset in WSTROBE drops mem_write without a clock.
    cpu.req = 1'b1; cpu.op = OP_WR; cpu.addr = 12'h005; cpu.wdata = 16'hABCD;
    @(posedge clk);
    @(negedge clk);
    cpu.req = 1'b0;
    @(negedge clk);
    chk("rst_pre_strobe", mem_write, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outs", all_outs(), 0);
    @(negedge clk);
    chk("rst_held_outs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_post_idle", all_outs(), 0);
    run_txn('{OP_WR, 12'h006, 16'h0F0F, 4, 16'h0000, 1'b0, 1'b0});
    run_txn('{OP_RD, 12'h006, 16'h0000, 2, 16'h0F0F, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_initiator.md
# mem_initiator

Memory-side initiator that turns single-cycle CPU control-unit requests into correctly sequenced accesses on the 4096x16 main-memory port (12-bit address, level-sensitive `read`/`write`, `indata`/`outdata`). It supports three operations: plain read, plain write and increment-in-place. Increment-in-place is a read-modify-write used by the ISZ instruction. The block guarantees that `read` and `write` are never asserted together, and that address and data are stable one full cycle before and after every write strobe. It sits between the control unit and the memory block.

## Interface
- ADDR_W, 12, memory address width
- DATA_W, 16, memory word width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  1  request strobe; sampled only when the block is ready (IDLE or DONE)
- op  in  2  operation: 00 READ, 01 WRITE, 10 INC, 11 reserved
- addr  in  ADDR_W  target address
- wdata  in  DATA_W  write data (used by WRITE only)
- busy  out  1  high while a transaction is in progress; low in IDLE and DONE
- done  out  1  one-cycle completion pulse
- err  out  1  high together with `done` when the op was reserved (11)
- rdata  out  DATA_W  READ: word read; INC: incremented word; WRITE: unchanged
- zero  out  1  `rdata == 0`, updated by READ and INC only
- mem_adress  out  ADDR_W  memory address
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable (level; memory writes while high)
- mem_indata  out  DATA_W  memory write data
- mem_outdata  in  DATA_W  memory read data, combinational from `mem_adress`

## Operation
- All outputs are registered.
- States: IDLE, RD, WSETUP, WSTROBE, WHOLD, DONE.
- Acceptance:
  - In IDLE or DONE, `req=1` latches `op`, `addr` and `wdata`.
  - `mem_adress` is loaded with `addr`; `mem_indata` is loaded with `wdata` for WRITE.
  - `req` in any other state is ignored and not queued.
- READ: IDLE/DONE -> RD -> DONE.
  - In RD: `mem_read=1`.
  - At the RD exit edge: `rdata <= mem_outdata`, `zero <= (mem_outdata == 0)`.
- WRITE: IDLE/DONE -> WSETUP -> WSTROBE -> WHOLD -> DONE.
  - `mem_write=1` only in WSTROBE.
  - `mem_adress` and `mem_indata` are constant across WSETUP..WHOLD.
- INC: IDLE/DONE -> RD -> WSETUP -> WSTROBE -> WHOLD -> DONE.
  - At the RD exit edge, `s = mem_outdata + 1` mod 2^DATA_W (16'hFFFF wraps to 0).
  - `rdata <= s`, `mem_indata <= s`, `zero <= (s == 0)`.
  - The write phase is identical to WRITE.
- Reserved op (11): IDLE/DONE -> DONE with `err=1`. No memory activity; `rdata` and `zero` unchanged.
- DONE:
  - `done=1` for exactly this one cycle.
  - With no `req`, next state is IDLE.
  - With `req`, the new transaction is accepted (back-to-back).
- Memory-port invariant: `mem_read & mem_write` is never 1 in any state.
- `mem_adress` and `mem_indata` hold their last values in IDLE and DONE.
- Reset (async, `rst_n=0`), including mid-transaction:
  - State goes to IDLE immediately.
  - All outputs go to 0: `busy`, `done`, `err`, `rdata`, `zero`, `mem_adress`, `mem_read`, `mem_write`, `mem_indata`.
  - `mem_write` drops without waiting for a clock. An interrupted write may or may not have landed; the requester must reissue it.
  - No pending request survives reset.

## Timing
- E0 is the accepting edge; done is high in the cycle following the listed edge.
- READ: done after E1 (2 cycles accept-to-done).
- WRITE: `mem_write` high E1..E2; done after E3.
- INC:
  - `mem_read` high E0..E1.
  - `mem_write` high E2..E3.
  - done after E4.
- Reserved op: done and err after E0.
- `busy` rises with the first non-IDLE/DONE state after E0. It is low in the DONE cycle.
- Back-to-back: a `req` held high through the DONE cycle is accepted at the DONE exit edge. No idle gap.
- `rdata` and `zero` are valid from the DONE cycle and held until the next READ or INC completes.

## Test plan
- Reset/idle:
  - Assert `rst_n=0` with X-free inputs -> all outputs 0.
  - Release reset, `req=0` for 10 cycles -> `busy`, `mem_read` and `mem_write` stay 0.
- WRITE then READ:
  - WRITE addr 12'h0A5, wdata 16'h1234 -> `mem_write` is high exactly 1 cycle, with `mem_adress=0A5` and `mem_indata=1234` steady for 3 cycles, done at cycle 4.
  - READ 12'h0A5 -> done at cycle 2, `rdata=16'h1234`, `zero=0`.
- INC wrap:
  - Preload 12'hFFF with 16'hFFFF, then INC 12'hFFF -> `rdata=0`, `zero=1`, done at cycle 5.
  - Memory word at 12'hFFF reads back 0.
  - `mem_read & mem_write` is never 1 (checked by assertion throughout all tests).
- Back-to-back plus ignored req:
  - Hold `req` high across READ 12'h001, then WRITE 12'h002 -> second transaction accepted in the DONE cycle, no gap.
  - Toggle `req` mid-WRITE -> no extra transaction.
- Reserved op: op=11 -> `done=err=1` one cycle after accept, `mem_read=mem_write=0`, `rdata` unchanged.
- Reset mid-write: drop `rst_n` during WSTROBE -> `mem_write=0` asynchronously, state IDLE, all outputs 0; the next request completes normally.
